// File: rtl/vx_tag_flush_arb_if.sv
// rtl/vx_tag_flush_arb_if.sv - request/grant bundle between bank queues, flush control and tag stage
// Ports (slave = arbiter side):
//   flush_req/flush_busy/flush_done   flush control
//   lookup_valid/lookup_addr/lookup_ready  core lookup request
//   fill_valid/fill_addr/fill_ready        memory fill request
//   tag_valid/tag_op/tag_addr/tag_ready    tag-store port
interface vx_tag_flush_arb_if #(
  parameter int LINE_ADDR_WIDTH = 26
);
  logic                       flush_req;
  logic                       flush_busy;
  logic                       flush_done;
  logic                       lookup_valid;
  logic [LINE_ADDR_WIDTH-1:0] lookup_addr;
  logic                       lookup_ready;
  logic                       fill_valid;
  logic [LINE_ADDR_WIDTH-1:0] fill_addr;
  logic                       fill_ready;
  logic                       tag_valid;
  logic [1:0]                 tag_op;
  logic [LINE_ADDR_WIDTH-1:0] tag_addr;
  logic                       tag_ready;

  modport master (
    output flush_req, lookup_valid, lookup_addr, fill_valid, fill_addr, tag_ready,
    input  flush_busy, flush_done, lookup_ready, fill_ready, tag_valid, tag_op, tag_addr
  );

  modport slave (
    input  flush_req, lookup_valid, lookup_addr, fill_valid, fill_addr, tag_ready,
    output flush_busy, flush_done, lookup_ready, fill_ready, tag_valid, tag_op, tag_addr
  );
endinterface

// File: rtl/vx_tag_flush_arb.sv
// rtl/vx_tag_flush_arb.sv - tag-store port scheduler: invalidate walker, fills and lookups
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    vx_tag_flush_arb_if.slave (flush control, lookup/fill requests, tag port)
module vx_tag_flush_arb #(
  parameter int CACHE_SIZE      = 16384,
  parameter int CACHE_LINE_SIZE = 64,
  parameter int NUM_BANKS       = 4,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int FILL_BURST_MAX  = 4
) (
  input  logic               clk,
  input  logic               reset,
  vx_tag_flush_arb_if.slave  bus
);
  localparam int NUM_LINES        = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS);
  localparam int LINE_SELECT_BITS = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int STREAK_BITS      = $clog2(FILL_BURST_MAX + 1);

  localparam logic [LINE_SELECT_BITS-1:0] LAST_LINE  = LINE_SELECT_BITS'(NUM_LINES - 1);
  localparam logic [STREAK_BITS-1:0]      STREAK_MAX = STREAK_BITS'(FILL_BURST_MAX);

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_FILL   = 2'd1;
  localparam logic [1:0] OP_INVAL  = 2'd2;

  typedef enum logic [1:0] {
    S_INIT,
    S_FLUSH,
    S_IDLE
  } state_t;

  state_t                      state;
  logic [LINE_SELECT_BITS-1:0] line_cnt;
  logic [STREAK_BITS-1:0]      fill_streak;
  logic                        flush_done_q;
  logic                        lookup_wins;
  logic                        lookup_fire;
  logic                        fill_fire;

  // Fill normally wins; once FILL_BURST_MAX fills have gone by a waiting
  // lookup, the lookup takes the port so it cannot starve.
  always_comb begin
    lookup_wins      = bus.lookup_valid && (!bus.fill_valid || fill_streak == STREAK_MAX);
    bus.tag_valid    = 1'b0;
    bus.tag_op       = OP_LOOKUP;
    bus.tag_addr     = '0;
    bus.lookup_ready = 1'b0;
    bus.fill_ready   = 1'b0;
    case (state)
      S_FLUSH: begin
        bus.tag_valid = 1'b1;
        bus.tag_op    = OP_INVAL;
        bus.tag_addr  = LINE_ADDR_WIDTH'(line_cnt);
      end
      S_IDLE: begin
        if (lookup_wins) begin
          bus.tag_valid    = 1'b1;
          bus.tag_op       = OP_LOOKUP;
          bus.tag_addr     = bus.lookup_addr;
          bus.lookup_ready = bus.tag_ready;
        end else if (bus.fill_valid) begin
          bus.tag_valid  = 1'b1;
          bus.tag_op     = OP_FILL;
          bus.tag_addr   = bus.fill_addr;
          bus.fill_ready = bus.tag_ready;
        end
      end
      default: ;
    endcase
  end

  assign lookup_fire    = bus.lookup_valid && bus.lookup_ready;
  assign fill_fire      = bus.fill_valid && bus.fill_ready;
  assign bus.flush_busy = (state != S_IDLE);
  assign bus.flush_done = flush_done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_INIT;
      line_cnt     <= '0;
      fill_streak  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state)
        S_INIT: begin
          state    <= S_FLUSH;
          line_cnt <= '0;
        end
        S_FLUSH: begin
          if (bus.tag_ready) begin
            if (line_cnt == LAST_LINE) begin
              state        <= S_IDLE;
              flush_done_q <= 1'b1;
            end else begin
              line_cnt <= line_cnt + 1'b1;
            end
          end
        end
        S_IDLE: begin
          // Walker requests arriving while busy are dropped, not queued.
          if (bus.flush_req) begin
            state    <= S_FLUSH;
            line_cnt <= '0;
          end
        end
        default: state <= S_INIT;
      endcase

      // Streak only measures fills granted past a lookup that is actually waiting.
      if (!bus.lookup_valid || lookup_fire) begin
        fill_streak <= '0;
      end else if (fill_fire && fill_streak != STREAK_MAX) begin
        fill_streak <= fill_streak + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vx_tag_flush_arb.sv
// tb/tb_vx_tag_flush_arb.sv - self-checking bench for vx_tag_flush_arb
module tb_vx_tag_flush_arb;
  localparam int AW  = 26;
  localparam int NL  = 16384 / (64 * 4);
  localparam int FBM = 4;
  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_FILL   = 2'd1;
  localparam logic [1:0] OP_INVAL  = 2'd2;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          valid;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic          lrdy;
    logic          frdy;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  vx_tag_flush_arb_if #(.LINE_ADDR_WIDTH(AW)) bus ();

  vx_tag_flush_arb #(
    .CACHE_SIZE(16384),
    .CACHE_LINE_SIZE(64),
    .NUM_BANKS(4),
    .LINE_ADDR_WIDTH(AW),
    .FILL_BURST_MAX(FBM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.busy  = bus.flush_busy;
    o.done  = bus.flush_done;
    o.valid = bus.tag_valid;
    o.op    = bus.tag_op;
    o.addr  = bus.tag_addr;
    o.lrdy  = bus.lookup_ready;
    o.frdy  = bus.fill_ready;
    return o;
  endfunction

  function automatic obs_t mk(input logic busy, input logic done, input logic valid,
                              input logic [1:0] op, input logic [AW-1:0] addr,
                              input logic lrdy, input logic frdy);
    obs_t o;
    o.busy  = busy;
    o.done  = done;
    o.valid = valid;
    o.op    = op;
    o.addr  = addr;
    o.lrdy  = lrdy;
    o.frdy  = frdy;
    return o;
  endfunction

  task automatic quiet();
    bus.flush_req    = 1'b0;
    bus.lookup_valid = 1'b0;
    bus.lookup_addr  = '0;
    bus.fill_valid   = 1'b0;
    bus.fill_addr    = '0;
    bus.tag_ready    = 1'b1;
  endtask

  // Drives one walk from its first INVAL cycle through the cycle after flush_done.
  // Reference: the address shown equals the number of INVALs accepted so far.
  task automatic run_walk(input string name, input int mode, input bit lookup_pend,
                          input int reflush_at, input int stop_at, output int flush_cycles);
    int   accepted = 0;
    int   stall = 0;
    obs_t exp_o;
    obs_t got;
    flush_cycles = 0;
    while (accepted < NL) begin
      if (flush_cycles > 8 * NL) begin
        total++; bad++;
        $display("FAIL %s_timeout accepted=%0d required=%0d", name, accepted, NL);
        return;
      end
      case (mode)
        0: bus.tag_ready = 1'b1;
        1: begin
          if (accepted == 10 && stall < 3) begin
            bus.tag_ready = 1'b0;
            stall++;
          end else begin
            bus.tag_ready = 1'b1;
          end
        end
        default: bus.tag_ready = 1'($urandom_range(0, 1));
      endcase
      bus.flush_req    = (accepted == reflush_at);
      bus.lookup_valid = lookup_pend;
      bus.lookup_addr  = AW'('h2a5);
      @(negedge clk);
      exp_o = mk(1'b1, 1'b0, 1'b1, OP_INVAL, AW'(accepted), 1'b0, 1'b0);
      got   = observe();
      total++;
      if (got !== exp_o) begin
        bad++;
        $display("FAIL %s_inval n=%0d got=%p required=%p", name, accepted, got, exp_o);
      end
      if (accepted == stop_at) return;
      if (bus.tag_ready) accepted++;
      flush_cycles++;
      @(posedge clk); #1;
    end
    bus.flush_req = 1'b0;
    bus.tag_ready = 1'b1;
    @(negedge clk);
    if (lookup_pend) exp_o = mk(1'b0, 1'b1, 1'b1, OP_LOOKUP, AW'('h2a5), 1'b1, 1'b0);
    else             exp_o = mk(1'b0, 1'b1, 1'b0, OP_LOOKUP, '0, 1'b0, 1'b0);
    got = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL %s_done got=%p required=%p", name, got, exp_o);
    end
    @(posedge clk); #1;
    bus.lookup_valid = 1'b0;
    @(negedge clk);
    exp_o = mk(1'b0, 1'b0, 1'b0, OP_LOOKUP, '0, 1'b0, 1'b0);
    got   = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL %s_after_done got=%p required=%p", name, got, exp_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic start_flush();
    quiet();
    bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.flush_req = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t exp_o;
    quiet();
    reset            = 1'b1;
    bus.lookup_valid = 1'b1;
    bus.fill_valid   = 1'b1;
    bus.flush_req    = 1'b1;
    bus.fill_addr    = AW'('h33);
    @(posedge clk);
    @(negedge clk);
    exp_o = mk(1'b1, 1'b0, 1'b0, OP_LOOKUP, '0, 1'b0, 1'b0);
    got   = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL reset_values got=%p required=%p", got, exp_o);
    end
  endtask

  task automatic test_power_up();
    int   n;
    obs_t got;
    obs_t exp_o;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    exp_o = mk(1'b1, 1'b0, 1'b0, OP_LOOKUP, '0, 1'b0, 1'b0);
    got   = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL init_cycle got=%p required=%p", got, exp_o);
    end
    @(posedge clk); #1;
    quiet();
    run_walk("powerup", 0, 1'b0, -1, -1, n);
    total++;
    if (n !== NL) begin
      bad++;
      $display("FAIL powerup_len got=%0d required=%0d", n, NL);
    end
  endtask

  task automatic test_priority();
    obs_t got;
    obs_t exp_o;
    quiet();
    bus.fill_valid   = 1'b1;
    bus.fill_addr    = AW'('h100);
    bus.lookup_valid = 1'b1;
    bus.lookup_addr  = AW'('h200);
    @(negedge clk);
    exp_o = mk(1'b0, 1'b0, 1'b1, OP_FILL, AW'('h100), 1'b0, 1'b1);
    got   = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL priority_fill got=%p required=%p", got, exp_o);
    end
    @(posedge clk); #1;
    quiet();
    bus.lookup_valid = 1'b1;
    bus.lookup_addr  = AW'('h200);
    bus.tag_ready    = 1'b0;
    @(negedge clk);
    exp_o = mk(1'b0, 1'b0, 1'b1, OP_LOOKUP, AW'('h200), 1'b0, 1'b0);
    got   = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL lookup_stalled got=%p required=%p", got, exp_o);
    end
    @(posedge clk); #1;
    quiet();
    @(posedge clk); #1;
  endtask

  task automatic test_anti_starvation();
    obs_t got;
    obs_t exp_o;
    quiet();
    bus.fill_valid   = 1'b1;
    bus.fill_addr    = AW'('h100);
    bus.lookup_valid = 1'b1;
    bus.lookup_addr  = AW'('h200);
    for (int i = 0; i < 3 * (FBM + 1); i++) begin
      @(negedge clk);
      if (i % (FBM + 1) == FBM) exp_o = mk(1'b0, 1'b0, 1'b1, OP_LOOKUP, AW'('h200), 1'b1, 1'b0);
      else                      exp_o = mk(1'b0, 1'b0, 1'b1, OP_FILL, AW'('h100), 1'b0, 1'b1);
      got = observe();
      total++;
      if (got !== exp_o) begin
        bad++;
        $display("FAIL starve_pattern i=%0d got=%p required=%p", i, got, exp_o);
      end
      @(posedge clk); #1;
    end
    quiet();
    @(posedge clk); #1;
  endtask

  // Reference: a waiting lookup may be passed over by at most FBM accepted fills;
  // the count restarts whenever no lookup is waiting or a lookup is accepted.
  task automatic test_random_arb();
    bit            fv = 0;
    bit            lv = 0;
    logic [AW-1:0] fa = '0;
    logic [AW-1:0] la = '0;
    int            passed_over = 0;
    bit            tr;
    bit            lookup_turn;
    obs_t          got;
    obs_t          exp_o;
    quiet();
    for (int c = 0; c < 400; c++) begin
      if (!fv) begin
        fv = ($urandom_range(0, 2) != 0);
        fa = AW'($urandom);
      end
      if (!lv) begin
        lv = ($urandom_range(0, 1) != 0);
        la = AW'($urandom);
      end
      tr = ($urandom_range(0, 3) != 0);
      bus.fill_valid   = fv;
      bus.fill_addr    = fa;
      bus.lookup_valid = lv;
      bus.lookup_addr  = la;
      bus.tag_ready    = tr;
      lookup_turn = lv && (!fv || passed_over >= FBM);
      if (lookup_turn)  exp_o = mk(1'b0, 1'b0, 1'b1, OP_LOOKUP, la, tr, 1'b0);
      else if (fv)      exp_o = mk(1'b0, 1'b0, 1'b1, OP_FILL, fa, 1'b0, tr);
      else              exp_o = mk(1'b0, 1'b0, 1'b0, OP_LOOKUP, '0, 1'b0, 1'b0);
      @(negedge clk);
      got = observe();
      total++;
      if (got !== exp_o) begin
        bad++;
        $display("FAIL random_arb c=%0d got=%p required=%p", c, got, exp_o);
      end
      if (!lv) passed_over = 0;
      else if (lookup_turn && tr) passed_over = 0;
      else if (!lookup_turn && fv && tr && passed_over < FBM) passed_over++;
      if (tr && lookup_turn) lv = 0;
      else if (tr && fv) fv = 0;
      @(posedge clk); #1;
    end
    quiet();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int n;
    start_flush();
    run_walk("backpressure", 1, 1'b0, -1, -1, n);
    total++;
    if (n !== NL + 3) begin
      bad++;
      $display("FAIL backpressure_len got=%0d required=%0d", n, NL + 3);
    end
  endtask

  task automatic test_flush_blocking();
    int n;
    start_flush();
    run_walk("flush_block", 0, 1'b1, 20, -1, n);
    total++;
    if (n !== NL) begin
      bad++;
      $display("FAIL flush_block_len got=%0d required=%0d", n, NL);
    end
  endtask

  task automatic test_random_walk();
    int n;
    start_flush();
    run_walk("random_walk", 2, 1'b0, -1, -1, n);
  endtask

  task automatic test_async_reset();
    int   n;
    obs_t got;
    obs_t exp_o;
    start_flush();
    run_walk("abort", 0, 1'b0, -1, 30, n);
    #2;
    reset = 1'b1;
    #1;
    exp_o = mk(1'b1, 1'b0, 1'b0, OP_LOOKUP, '0, 1'b0, 1'b0);
    got   = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL async_reset got=%p required=%p", got, exp_o);
    end
    quiet();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    got = observe();
    total++;
    if (got !== exp_o) begin
      bad++;
      $display("FAIL reinit_cycle got=%p required=%p", got, exp_o);
    end
    @(posedge clk); #1;
    run_walk("restart", 0, 1'b0, -1, -1, n);
    total++;
    if (n !== NL) begin
      bad++;
      $display("FAIL restart_len got=%0d required=%0d", n, NL);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_priority();
    test_anti_starvation();
    test_random_arb();
    test_backpressure();
    test_flush_blocking();
    test_random_walk();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
